mon_date_counter: RTL and testbench
===================================

MON_DATE_COUNTER -- requirements
Module: mon_date_counter

Interface
REQ-001 Parameter: YEAR_INIT, default 8'h00, BCD year loaded on reset (00-99).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: day_tick  input  1  one-cycle pulse; midnight carry from the time-of-day counter.
REQ-005 Port: mon_inc  input  1  one-cycle pulse from the one-pulse stage; set-mode month advance.
REQ-006 Port: date_inc  input  1  one-cycle pulse from the one-pulse stage; set-mode date advance.
REQ-007 Port: mon_bcd  output  8  month, BCD, 01-12.
REQ-008 Port: date_bcd  output  8  day of month, BCD, 01-31.
REQ-009 Port: year_bcd  output  8  year, BCD, 00-99.
REQ-010 Port: year_carry  output  1  registered one-cycle pulse on the 99->00 year rollover.

Function
REQ-011 All outputs SHALL be registered and SHALL update on the rising clk edge that samples the qualifying input, giving 1-cycle latency.
REQ-012 Inputs SHALL be treated as single-cycle pulses; an input held high for N cycles SHALL act N times.
REQ-013 Priority: day_tick > mon_inc > date_inc; in a cycle with several asserted, only the highest SHALL act and the others SHALL be discarded.
REQ-014 Month length SHALL be: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; Feb per REQ-025/026.
REQ-015 day_tick, date < month length: date +1, month and year unchanged.
REQ-016 day_tick, date = month length, month < 12: date -> 01, month +1.
REQ-017 day_tick on 12/31: date -> 01, month -> 01, year +1 in BCD; 99 wraps to 00 and year_carry SHALL assert for exactly that one cycle.
REQ-018 date_inc: date +1; at month length, date wraps to 01; no carry into month or year.
REQ-019 mon_inc: month +1, 12 wraps to 01, no carry into year; if the current date exceeds the new month's length, date SHALL be clamped to that length in the same cycle.
REQ-020 BCD arithmetic SHALL carry ones 9 -> tens +1; no digit SHALL ever hold A-F.
REQ-021 year_carry SHALL be 0 in every cycle except the one following a REQ-017 rollover.
REQ-022 No input combination SHALL produce an invalid date, e.g. 02/30 or 04/31.

Reset
REQ-023 rst asserted SHALL immediately, without waiting for clk, force mon_bcd=8'h01, date_bcd=8'h01, year_bcd=YEAR_INIT, and year_carry=0.
REQ-024 Pulses arriving while rst is high SHALL be ignored; the first pulse sampled after deassertion SHALL act normally, including when reset hit mid-rollover.

Configuration
REQ-025 With macro LEAP_YEAR_EN defined: February length SHALL be 29 when year_bcd is a multiple of 4 (00,04,...,96), else 28.
REQ-026 Without LEAP_YEAR_EN: February length SHALL always be 28 and no leap-detection logic SHALL be present.

Verification
REQ-027 Reset: assert rst mid-cycle with state 07/15/42 -> outputs go to 01/01/00 asynchronously; year_carry=0.
REQ-028 Rollover: preload 12/31/99, one day_tick -> next cycle 01/01/00, year_carry=1 for one cycle, then 0.
REQ-029 Leap: state 02/28/04 plus day_tick -> 02/29/04 with LEAP_YEAR_EN, 03/01/04 without; state 02/28/05 plus day_tick -> 03/01/05 in both builds.
REQ-030 Clamp: state 01/31/10 plus mon_inc -> 02/28/10; state 03/31/10 plus mon_inc -> 04/30/10.
REQ-031 Set wrap: state 04/30/10 plus date_inc -> 04/01/10 with month unchanged; state 12/05/10 plus mon_inc -> 01/05/10 with year unchanged.
REQ-032 Priority: state 06/30/10 with day_tick, mon_inc and date_inc in the same cycle -> 07/01/10 only; the month is not advanced twice.

Source files
------------

// File: rtl/mon_date_counter.sv
// Month/date/year BCD calendar counter with set-mode month and date advance.
// Define LEAP_YEAR_EN to give February 29 days in years divisible by four.
module mon_date_counter #(
   parameter logic [7:0] YEAR_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       day_tick,
   input  logic       mon_inc,
   input  logic       date_inc,
   output logic [7:0] mon_bcd,
   output logic [7:0] date_bcd,
   output logic [7:0] year_bcd,
   output logic       year_carry
);

   logic [7:0] mon_q;
   logic [7:0] date_q;
   logic [7:0] year_q;
   logic       carry_q;

   logic [7:0] feb_len;
   logic [7:0] cur_len;
   logic [7:0] nxt_len;
   logic [7:0] nxt_mon;
   logic [7:0] nxt_year;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] len_of(input logic [7:0] m,
                                         input logic [7:0] feb);
      logic [7:0] r;
      unique case (m)
         8'h02:                      r = feb;
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

`ifdef LEAP_YEAR_EN
   // BCD year is a multiple of 4: even tens with ones 0/4/8, odd tens with 2/6
   logic leap;
   always_comb begin
      if (year_q[4])
         leap = (year_q[3:0] == 4'd2) || (year_q[3:0] == 4'd6);
      else
         leap = (year_q[3:0] == 4'd0) || (year_q[3:0] == 4'd4) ||
                (year_q[3:0] == 4'd8);
      feb_len = leap ? 8'h29 : 8'h28;
   end
`else
   assign feb_len = 8'h28;
`endif

   always_comb begin
      nxt_mon  = (mon_q == 8'h12) ? 8'h01 : bcd_inc(mon_q);
      nxt_year = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
      cur_len  = len_of(mon_q, feb_len);
      nxt_len  = len_of(nxt_mon, feb_len);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_q   <= 8'h01;
         date_q  <= 8'h01;
         year_q  <= YEAR_INIT;
         carry_q <= 1'b0;
      end else begin
         carry_q <= 1'b0;
         if (day_tick) begin
            if (date_q == cur_len) begin
               date_q <= 8'h01;
               mon_q  <= nxt_mon;
               if (mon_q == 8'h12) begin
                  year_q  <= nxt_year;
                  carry_q <= (year_q == 8'h99);
               end
            end else begin
               date_q <= bcd_inc(date_q);
            end
         end else if (mon_inc) begin
            mon_q <= nxt_mon;
            // BCD compares like binary, so clamp straight to the new length
            if (date_q > nxt_len) date_q <= nxt_len;
         end else if (date_inc) begin
            date_q <= (date_q == cur_len) ? 8'h01 : bcd_inc(date_q);
         end
      end
   end

   assign mon_bcd    = mon_q;
   assign date_bcd   = date_q;
   assign year_bcd   = year_q;
   assign year_carry = carry_q;

endmodule

// File: tb/tb_mon_date_counter.sv
// Bench for mon_date_counter: integer calendar model, directed and random pulses.
// Build with LEAP_YEAR_EN defined to check the leap-year variant.
module tb_mon_date_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       day_tick = 1'b0;
   logic       mon_inc = 1'b0;
   logic       date_inc = 1'b0;
   logic [7:0] mon_bcd;
   logic [7:0] date_bcd;
   logic [7:0] year_bcd;
   logic       year_carry;

   int vectors = 0;
   int errors  = 0;

`ifdef LEAP_YEAR_EN
   localparam bit LEAP = 1'b1;
`else
   localparam bit LEAP = 1'b0;
`endif

   int mm = 1, md = 1, my = 0;
   bit mc = 1'b0;

   mon_date_counter dut (
      .clk(clk), .rst(rst), .day_tick(day_tick), .mon_inc(mon_inc),
      .date_inc(date_inc), .mon_bcd(mon_bcd), .date_bcd(date_bcd),
      .year_bcd(year_bcd), .year_carry(year_carry)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic int mlen(input int m, input int y);
      if (m == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic void model_apply(input bit dt, input bit mi, input bit di);
      mc = 1'b0;
      if (dt) begin
         if (md < mlen(mm, my)) md++;
         else begin
            md = 1;
            if (mm < 12) mm++;
            else begin
               mm = 1;
               if (my == 99) begin my = 0; mc = 1'b1; end
               else my++;
            end
         end
      end else if (mi) begin
         mm = (mm == 12) ? 1 : mm + 1;
         if (md > mlen(mm, my)) md = mlen(mm, my);
      end else if (di) begin
         md = (md == mlen(mm, my)) ? 1 : md + 1;
      end
   endfunction

   task automatic step(input bit dt, input bit mi, input bit di);
      @(negedge clk);
      day_tick = dt; mon_inc = mi; date_inc = di;
      @(posedge clk);
      #1;
      day_tick = 1'b0; mon_inc = 1'b0; date_inc = 1'b0;
      model_apply(dt, mi, di);
      vectors++;
      if ({mon_bcd, date_bcd, year_bcd, year_carry} !==
          {bcd(mm), bcd(md), bcd(my), mc}) begin
         errors++;
         $display("FAIL step dt=%0b mi=%0b di=%0b: got %h/%h/%h c=%b want %h/%h/%h c=%b",
                  dt, mi, di, mon_bcd, date_bcd, year_bcd, year_carry,
                  bcd(mm), bcd(md), bcd(my), mc);
      end
   endtask

   task automatic goto_date(input int m, input int d, input int y);
      while (my != y) begin
         while (mm != 12) step(1'b0, 1'b1, 1'b0);
         while (md != 31) step(1'b0, 1'b0, 1'b1);
         step(1'b1, 1'b0, 1'b0);
      end
      while (mm != m) step(1'b0, 1'b1, 1'b0);
      while (md != d) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic expect_out(input string name, input logic [24:0] want);
      vectors++;
      if ({mon_bcd, date_bcd, year_bcd, year_carry} !== want) begin
         errors++;
         $display("FAIL %s: got %h/%h/%h c=%b want %h/%h/%h c=%b", name,
                  mon_bcd, date_bcd, year_bcd, year_carry,
                  want[24:17], want[16:9], want[8:1], want[0]);
      end
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      #1 expect_out("initial_reset", {8'h01, 8'h01, 8'h00, 1'b0});
      @(negedge clk) rst = 1'b0;
      mm = 1; md = 1; my = 0; mc = 1'b0;
      goto_date(7, 15, 42);
      expect_out("preload_071542", {8'h07, 8'h15, 8'h42, 1'b0});
      @(posedge clk);
      #3 rst = 1'b1;
      #1 expect_out("async_reset", {8'h01, 8'h01, 8'h00, 1'b0});
      day_tick = 1'b1; mon_inc = 1'b1; date_inc = 1'b1;
      repeat (2) @(posedge clk);
      #1 expect_out("pulses_in_reset", {8'h01, 8'h01, 8'h00, 1'b0});
      day_tick = 1'b0; mon_inc = 1'b0; date_inc = 1'b0;
      @(negedge clk) rst = 1'b0;
      mm = 1; md = 1; my = 0; mc = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      expect_out("first_after_reset", {8'h01, 8'h02, 8'h00, 1'b0});
   endtask

   task automatic test_leap;
      goto_date(2, 28, 4);
      step(1'b1, 1'b0, 1'b0);
      if (LEAP) expect_out("leap_04", {8'h02, 8'h29, 8'h04, 1'b0});
      else      expect_out("noleap_04", {8'h03, 8'h01, 8'h04, 1'b0});
      goto_date(2, 28, 5);
      step(1'b1, 1'b0, 1'b0);
      expect_out("feb28_05", {8'h03, 8'h01, 8'h05, 1'b0});
   endtask

   task automatic test_clamp;
      goto_date(1, 31, 10);
      step(1'b0, 1'b1, 1'b0);
      expect_out("clamp_feb", {8'h02, 8'h28, 8'h10, 1'b0});
      goto_date(3, 31, 10);
      step(1'b0, 1'b1, 1'b0);
      expect_out("clamp_apr", {8'h04, 8'h30, 8'h10, 1'b0});
   endtask

   task automatic test_set_wrap;
      goto_date(4, 30, 10);
      step(1'b0, 1'b0, 1'b1);
      expect_out("date_wrap", {8'h04, 8'h01, 8'h10, 1'b0});
      goto_date(12, 5, 10);
      step(1'b0, 1'b1, 1'b0);
      expect_out("mon_wrap", {8'h01, 8'h05, 8'h10, 1'b0});
   endtask

   task automatic test_priority;
      goto_date(6, 30, 10);
      step(1'b1, 1'b1, 1'b1);
      expect_out("priority", {8'h07, 8'h01, 8'h10, 1'b0});
   endtask

   task automatic test_rollover;
      goto_date(12, 31, 99);
      step(1'b1, 1'b0, 1'b0);
      expect_out("rollover", {8'h01, 8'h01, 8'h00, 1'b1});
      step(1'b0, 1'b0, 1'b0);
      expect_out("carry_drop", {8'h01, 8'h01, 8'h00, 1'b0});
      goto_date(12, 31, 99);
      step(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 expect_out("reset_mid_roll", {8'h01, 8'h01, 8'h00, 1'b0});
      @(negedge clk) rst = 1'b0;
      mm = 1; md = 1; my = 0; mc = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      expect_out("tick_after_roll_rst", {8'h01, 8'h02, 8'h00, 1'b0});
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++)
         step($urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
              $urandom_range(3, 0) == 0);
   endtask

   task automatic test_back_to_back;
      goto_date(11, 29, my);
      repeat (40) step(1'b1, 1'b0, 1'b0);
      repeat (14) step(1'b0, 1'b1, 1'b0);
      repeat (35) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_leap();
      test_clamp();
      test_set_wrap();
      test_priority();
      test_rollover();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
